// File: rtl/reg_data_reader_pkg.sv
// ---------------------------------------------------------------------------
// reg_data_reader_pkg
//
// Shared definitions for the register-file read side:
//   - WIDTH_DEFAULT : default register / operand data width
//   - state_e       : read sequencer state encoding (2-bit)
//   - is_busy()     : helper decoding the Busy condition from a state
// ---------------------------------------------------------------------------
package reg_data_reader_pkg;

  localparam int WIDTH_DEFAULT = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RD_RD = 2'd1,
    ST_RD_RS = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  function automatic logic is_busy(input state_e st);
    return (st != ST_IDLE);
  endfunction

endpackage : reg_data_reader_pkg

// File: rtl/reg_data_reader_fwd_sel.sv
// ---------------------------------------------------------------------------
// reg_fwd_sel
//
// Combinational one-bit-address register select with write forwarding.
// Returns the selected register value, overridden by a snooped write that
// targets the same address. The Rd-side write (port 1) has priority over the
// Rs-side write (port 2) when both target the address.
//
// Parameters:
//   WIDTH  : data width
//   FWD_EN : 1 = apply forwarding, 0 = plain register value
//
// Ports:
//   addr            in   register address being read
//   reg0, reg1      in   current register contents
//   wr_in1, wr_in2  in   snooped Rd / Rs write data
//   wr_a1, wr_a2    in   snooped Rd / Rs write address
//   wr_en1, wr_en2  in   snooped Rd / Rs write enables
//   data            out  selected (possibly forwarded) value
//   hit             out  a snooped write targets addr (always 0 if !FWD_EN)
// ---------------------------------------------------------------------------
module reg_fwd_sel #(
  parameter int WIDTH  = 16,
  parameter bit FWD_EN = 1'b1
) (
  input  logic             addr,
  input  logic [WIDTH-1:0] reg0,
  input  logic [WIDTH-1:0] reg1,
  input  logic [WIDTH-1:0] wr_in1,
  input  logic [WIDTH-1:0] wr_in2,
  input  logic             wr_a1,
  input  logic             wr_a2,
  input  logic             wr_en1,
  input  logic             wr_en2,
  output logic [WIDTH-1:0] data,
  output logic             hit
);

  logic hit1;
  logic hit2;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned and no latch is inferred.
    data = addr ? reg1 : reg0;
    hit  = 1'b0;
    hit1 = FWD_EN && wr_en1 && (wr_a1 == addr);
    hit2 = FWD_EN && wr_en2 && (wr_a2 == addr);
    if (hit1) begin
      data = wr_in1;
      hit  = 1'b1;
    end else if (hit2) begin
      data = wr_in2;
      hit  = 1'b1;
    end
  end

endmodule : reg_fwd_sel

// File: rtl/reg_data_reader.sv
// ---------------------------------------------------------------------------
// reg_data_reader
//
// Read side of the two-register file. A request captures an Rd address and
// an Rs address; the operands are read one per cycle through one shared read
// mux and held on Out1/Out2 under a Valid/Ack handshake. Snooped writes are
// forwarded into the capture registers so a read never returns data older
// than a same-cycle write.
//
// Sequence: IDLE -> RD_RD -> [RD_RS] -> DONE -> IDLE
//   RD_RS is skipped when both addresses are equal (Out2 copies Out1).
//
// Compile-time option:
//   REG_READER_FWD_EN  defined   : forwarding in RD_RD/RD_RS, and snooped
//                                  writes keep Out1/Out2 coherent in DONE
//                      undefined : plain register reads, outputs frozen
//                                  in DONE
//
// Ports:
//   CLK            in   system clock, rising edge
//   nRST           in   asynchronous active-low reset
//   Reg0, Reg1     in   register contents
//   WrIn1, WrIn2   in   snooped Rd / Rs write data
//   WrA1, WrA2     in   snooped Rd / Rs write address
//   WrEn1, WrEn2   in   snooped Rd / Rs write enables
//   Req            in   read request (sampled only in IDLE)
//   A1, A2         in   Rd / Rs read addresses, captured with Req
//   Ack            in   consumer accepts Out1/Out2 (sampled only in DONE)
//   Out1, Out2     out  registered Rd / Rs operands
//   Valid          out  Out1/Out2 hold a complete result
//   Busy           out  request in progress
// ---------------------------------------------------------------------------
module reg_data_reader
  import reg_data_reader_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic [WIDTH-1:0] Reg0,
  input  logic [WIDTH-1:0] Reg1,
  input  logic [WIDTH-1:0] WrIn1,
  input  logic [WIDTH-1:0] WrIn2,
  input  logic             WrA1,
  input  logic             WrA2,
  input  logic             WrEn1,
  input  logic             WrEn2,
  input  logic             Req,
  input  logic             A1,
  input  logic             A2,
  input  logic             Ack,
  output logic [WIDTH-1:0] Out1,
  output logic [WIDTH-1:0] Out2,
  output logic             Valid,
  output logic             Busy
);

`ifdef REG_READER_FWD_EN
  localparam bit FwdEn = 1'b1;
`else
  localparam bit FwdEn = 1'b0;
`endif

  state_e           state_q, state_d;
  logic             addr1_q, addr1_d;
  logic             addr2_q, addr2_d;
  logic [WIDTH-1:0] out1_q,  out1_d;
  logic [WIDTH-1:0] out2_q,  out2_d;

  // Shared read mux: Rd address in RD_RD, Rs address in RD_RS.
  logic             mux_addr;
  logic [WIDTH-1:0] mux_data;
  logic             unused_mux_hit;

  assign mux_addr = (state_q == ST_RD_RS) ? addr2_q : addr1_q;

  reg_fwd_sel #(
    .WIDTH  (WIDTH),
    .FWD_EN (FwdEn)
  ) u_read_mux (
    .addr   (mux_addr),
    .reg0   (Reg0),
    .reg1   (Reg1),
    .wr_in1 (WrIn1),
    .wr_in2 (WrIn2),
    .wr_a1  (WrA1),
    .wr_a2  (WrA2),
    .wr_en1 (WrEn1),
    .wr_en2 (WrEn2),
    .data   (mux_data),
    .hit    (unused_mux_hit)
  );

`ifdef REG_READER_FWD_EN
  // Coherence path for held operands: only a snooped write that hits the
  // captured address may touch Out1/Out2 while in DONE.
  logic [WIDTH-1:0] upd1_data;
  logic [WIDTH-1:0] upd2_data;
  logic             upd1_hit;
  logic             upd2_hit;

  reg_fwd_sel #(
    .WIDTH  (WIDTH),
    .FWD_EN (1'b1)
  ) u_upd1 (
    .addr   (addr1_q),
    .reg0   (Reg0),
    .reg1   (Reg1),
    .wr_in1 (WrIn1),
    .wr_in2 (WrIn2),
    .wr_a1  (WrA1),
    .wr_a2  (WrA2),
    .wr_en1 (WrEn1),
    .wr_en2 (WrEn2),
    .data   (upd1_data),
    .hit    (upd1_hit)
  );

  reg_fwd_sel #(
    .WIDTH  (WIDTH),
    .FWD_EN (1'b1)
  ) u_upd2 (
    .addr   (addr2_q),
    .reg0   (Reg0),
    .reg1   (Reg1),
    .wr_in1 (WrIn1),
    .wr_in2 (WrIn2),
    .wr_a1  (WrA1),
    .wr_a2  (WrA2),
    .wr_en1 (WrEn1),
    .wr_en2 (WrEn2),
    .data   (upd2_data),
    .hit    (upd2_hit)
  );
`endif

  // Next-state and capture logic.
  always_comb begin
    state_d = state_q;
    addr1_d = addr1_q;
    addr2_d = addr2_q;
    out1_d  = out1_q;
    out2_d  = out2_q;

    unique case (state_q)
      ST_IDLE: begin
        if (Req) begin
          addr1_d = A1;
          addr2_d = A2;
          state_d = ST_RD_RD;
        end
      end

      ST_RD_RD: begin
        out1_d = mux_data;
        if (addr1_q == addr2_q) begin
          // Same register for both operands: one read serves both.
          out2_d  = mux_data;
          state_d = ST_DONE;
        end else begin
          state_d = ST_RD_RS;
        end
      end

      ST_RD_RS: begin
        out2_d  = mux_data;
        state_d = ST_DONE;
      end

      ST_DONE: begin
`ifdef REG_READER_FWD_EN
        if (upd1_hit) out1_d = upd1_data;
        if (upd2_hit) out2_d = upd2_data;
`endif
        if (Ack) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of the others, independent of statement order.
  // Every flop here is control or a small operand register, so all of them
  // are reset; a discarded partial result must read back as zero.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= ST_IDLE;
      addr1_q <= 1'b0;
      addr2_q <= 1'b0;
      out1_q  <= '0;
      out2_q  <= '0;
    end else begin
      state_q <= state_d;
      addr1_q <= addr1_d;
      addr2_q <= addr2_d;
      out1_q  <= out1_d;
      out2_q  <= out2_d;
    end
  end

  assign Out1  = out1_q;
  assign Out2  = out2_q;
  assign Valid = (state_q == ST_DONE);
  assign Busy  = is_busy(state_q);

endmodule : reg_data_reader

// File: tb/tb_reg_data_reader.sv
// ---------------------------------------------------------------------------
// tb_reg_data_reader
//
// Directed bench for reg_data_reader. Inputs change 1 time unit after a
// rising edge and outputs are sampled at the same point, so each sample
// reflects exactly the edges counted so far. Expected operand values under
// forwarding follow REG_READER_FWD_EN, the same macro the design uses.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_reg_data_reader;

  localparam int W = 16;

  logic         CLK;
  logic         nRST;
  logic [W-1:0] Reg0, Reg1, WrIn1, WrIn2;
  logic         WrA1, WrA2, WrEn1, WrEn2;
  logic         Req, A1, A2, Ack;
  logic [W-1:0] Out1, Out2;
  logic         Valid, Busy;

  int tests_run;
  int tests_failed;

  reg_data_reader #(.WIDTH(W)) dut (
    .CLK   (CLK),
    .nRST  (nRST),
    .Reg0  (Reg0),
    .Reg1  (Reg1),
    .WrIn1 (WrIn1),
    .WrIn2 (WrIn2),
    .WrA1  (WrA1),
    .WrA2  (WrA2),
    .WrEn1 (WrEn1),
    .WrEn2 (WrEn2),
    .Req   (Req),
    .A1    (A1),
    .A2    (A2),
    .Ack   (Ack),
    .Out1  (Out1),
    .Out2  (Out2),
    .Valid (Valid),
    .Busy  (Busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // One rising edge, then settle.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_writes();
    WrEn1 = 1'b0; WrEn2 = 1'b0;
    WrA1  = 1'b0; WrA2  = 1'b0;
    WrIn1 = '0;   WrIn2 = '0;
  endtask

  task automatic test_reset();
    nRST = 1'b0;
    Req = 1'b0; A1 = 1'b0; A2 = 1'b0; Ack = 1'b0;
    Reg0 = 16'h1111; Reg1 = 16'h2222;
    clear_writes();
    #12;
    tests_run++;
    if ({Out1, Out2, Valid, Busy} !== {32'h0, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("FAIL reset_state: got out1=%h out2=%h valid=%b busy=%b, want 0 0 0 0",
               Out1, Out2, Valid, Busy);
    end
    @(negedge CLK);
    nRST = 1'b1;
    step();
    step();
    tests_run++;
    if ({Valid, Busy} !== 2'b00) begin
      tests_failed++;
      $display("FAIL idle_no_req: got valid=%b busy=%b, want 0 0", Valid, Busy);
    end
  endtask

  task automatic test_basic_read();
    Reg0 = 16'h1234; Reg1 = 16'hABCD;
    Req = 1'b1; A1 = 1'b0; A2 = 1'b1;
    step();                       // edge 1: RD_RD
    Req = 1'b0;
    tests_run++;
    if ({Valid, Busy} !== 2'b01) begin
      tests_failed++;
      $display("FAIL basic_edge1: got valid=%b busy=%b, want 0 1", Valid, Busy);
    end
    step();                       // edge 2: RD_RS
    tests_run++;
    if ({Valid, Busy} !== 2'b01) begin
      tests_failed++;
      $display("FAIL basic_edge2: got valid=%b busy=%b, want 0 1", Valid, Busy);
    end
    step();                       // edge 3: DONE
    tests_run++;
    if ({Valid, Busy, Out1, Out2} !== {2'b11, 16'h1234, 16'hABCD}) begin
      tests_failed++;
      $display("FAIL basic_done: got valid=%b busy=%b out1=%h out2=%h, want 1 1 1234 abcd",
               Valid, Busy, Out1, Out2);
    end
    Ack = 1'b1;
    step();
    Ack = 1'b0;
    Reg0 = 16'h0F0F; Reg1 = 16'hF0F0;
    step();
    tests_run++;
    if ({Valid, Busy, Out1, Out2} !== {2'b00, 16'h1234, 16'hABCD}) begin
      tests_failed++;
      $display("FAIL basic_ack_hold: got valid=%b busy=%b out1=%h out2=%h, want 0 0 1234 abcd",
               Valid, Busy, Out1, Out2);
    end
  endtask

  task automatic test_same_addr();
    Reg0 = 16'h0000; Reg1 = 16'h00FF;
    Req = 1'b1; A1 = 1'b1; A2 = 1'b1;
    step();
    Req = 1'b0;
    tests_run++;
    if ({Valid, Busy} !== 2'b01) begin
      tests_failed++;
      $display("FAIL same_edge1: got valid=%b busy=%b, want 0 1", Valid, Busy);
    end
    step();
    tests_run++;
    if ({Valid, Out1, Out2} !== {1'b1, 16'h00FF, 16'h00FF}) begin
      tests_failed++;
      $display("FAIL same_done: got valid=%b out1=%h out2=%h, want 1 00ff 00ff",
               Valid, Out1, Out2);
    end
    Ack = 1'b1;
    step();
    Ack = 1'b0;
  endtask

  task automatic test_forwarding();
    logic [W-1:0] exp1, exp2;
    Reg0 = 16'h1234; Reg1 = 16'hABCD;
    Req = 1'b1; A1 = 1'b0; A2 = 1'b1;
    step();                       // RD_RD
    Req = 1'b0;
    WrEn1 = 1'b1; WrA1 = 1'b0; WrIn1 = 16'h5555;
    WrEn2 = 1'b1; WrA2 = 1'b0; WrIn2 = 16'h6666;
    step();                       // Out1 captured
    clear_writes();
    step();                       // DONE
`ifdef REG_READER_FWD_EN
    exp1 = 16'h5555;
`else
    exp1 = 16'h1234;
`endif
    tests_run++;
    if ({Valid, Out1, Out2} !== {1'b1, exp1, 16'hABCD}) begin
      tests_failed++;
      $display("FAIL fwd_rd_priority: got valid=%b out1=%h out2=%h, want 1 %h abcd",
               Valid, Out1, Out2, exp1);
    end
    // Hold DONE and write the Rs register.
    WrEn2 = 1'b1; WrA2 = 1'b1; WrIn2 = 16'h7777;
    step();
    clear_writes();
`ifdef REG_READER_FWD_EN
    exp2 = 16'h7777;
`else
    exp2 = 16'hABCD;
`endif
    tests_run++;
    if ({Valid, Out1, Out2} !== {1'b1, exp1, exp2}) begin
      tests_failed++;
      $display("FAIL fwd_done_update: got valid=%b out1=%h out2=%h, want 1 %h %h",
               Valid, Out1, Out2, exp1, exp2);
    end
    Ack = 1'b1;
    step();
    Ack = 1'b0;
  endtask

  task automatic test_ignored_inputs();
    Reg0 = 16'hC0DE; Reg1 = 16'hBEEF;
    Req = 1'b1; A1 = 1'b1; A2 = 1'b0;
    step();                       // RD_RD; Req held high while busy
    A1 = 1'b0; A2 = 1'b1;         // late address change has no effect
    Ack = 1'b1;                   // Ack outside DONE
    step();                       // RD_RS
    step();                       // DONE (Ack sampled in RD_RS: ignored)
    Ack = 1'b0;
    step();                       // still DONE
    tests_run++;
    if ({Valid, Busy, Out1, Out2} !== {2'b11, 16'hBEEF, 16'hC0DE}) begin
      tests_failed++;
      $display("FAIL ignore_busy: got valid=%b busy=%b out1=%h out2=%h, want 1 1 beef c0de",
               Valid, Busy, Out1, Out2);
    end
    Ack = 1'b1;                   // Req still high in the Ack cycle
    step();
    Ack = 1'b0;
    Req = 1'b0;
    tests_run++;
    if ({Valid, Busy} !== 2'b00) begin
      tests_failed++;
      $display("FAIL ignore_ack_cycle_req: got valid=%b busy=%b, want 0 0", Valid, Busy);
    end
    step();
    tests_run++;
    if ({Valid, Busy} !== 2'b00) begin
      tests_failed++;
      $display("FAIL idle_stays_idle: got valid=%b busy=%b, want 0 0", Valid, Busy);
    end
  endtask

  task automatic test_reset_mid_op();
    Reg0 = 16'h1357; Reg1 = 16'h2468;
    Req = 1'b1; A1 = 1'b0; A2 = 1'b1;
    step();                       // RD_RD
    Req = 1'b0;
    step();                       // RD_RS, Out1 = 1357
    tests_run++;
    if ({Busy, Out1} !== {1'b1, 16'h1357}) begin
      tests_failed++;
      $display("FAIL mid_pre_reset: got busy=%b out1=%h, want 1 1357", Busy, Out1);
    end
    #2;
    nRST = 1'b0;
    #1;
    tests_run++;
    if ({Out1, Out2, Valid, Busy} !== {32'h0, 2'b00}) begin
      tests_failed++;
      $display("FAIL mid_reset: got out1=%h out2=%h valid=%b busy=%b, want 0 0 0 0",
               Out1, Out2, Valid, Busy);
    end
    @(negedge CLK);
    nRST = 1'b1;
    step();
    Reg0 = 16'h9999; Reg1 = 16'h4242;
    Req = 1'b1; A1 = 1'b1; A2 = 1'b0;
    step();
    Req = 1'b0;
    step();
    step();
    tests_run++;
    if ({Valid, Out1, Out2} !== {1'b1, 16'h4242, 16'h9999}) begin
      tests_failed++;
      $display("FAIL post_reset_read: got valid=%b out1=%h out2=%h, want 1 4242 9999",
               Valid, Out1, Out2);
    end
    Ack = 1'b1;
    step();
    Ack = 1'b0;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    test_reset();
    test_basic_read();
    test_same_addr();
    test_forwarding();
    test_ignored_inputs();
    test_reset_mid_op();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_reg_data_reader
